fill_check_arbiter: RTL and testbench
=====================================

FILL_CHECK_ARBITER -- requirements
Module: fill_check_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDW, default $clog2(NREQ), requester-id width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-005 req_valid  input  NREQ  per-requester command valid.
REQ-006 req_fill  input  2*NREQ  per-requester fill code, slice i = [2i+1:2i]: 00 fill '0, 01 fill '1, 10 hold, 11 invert.
REQ-007 req_ready  output  NREQ  one-hot grant/accept; bit i high only in the accept cycle.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  IDW  index of the requester whose command produced the result.
REQ-010 rsp_data  output  4  shared target register, type fill_pkg::fill_struct_t.
REQ-011 rsp_all_ones  output  1  result of rsp_data == '1 (unsized all-ones, 4'hF).
REQ-012 rsp_ready  input  1  consumer accepts result.

Function
REQ-013 One shared 4-bit packed-struct target register (tgt); one command in flight at a time.
REQ-014 FSM states: IDLE, APPLY, CHECK, RESP; encoding from the package enum.
REQ-015 IDLE: if any req_valid is high, grant the first valid requester at or after rr_ptr (wrap modulo NREQ), assert that req_ready bit in the same cycle, latch code and id, go to APPLY; otherwise stay in IDLE.
REQ-016 req_ready is all zeros in every state other than IDLE.
REQ-017 req_ready is all zeros in IDLE when no req_valid is high.
REQ-018 APPLY (1 cycle): tgt <= 4'h0 / 4'hF / tgt / ~tgt for codes 00/01/10/11; go to CHECK.
REQ-019 CHECK (1 cycle): register all_ones = (tgt == 4'hF); go to RESP.
REQ-020 RESP: rsp_valid = 1, with rsp_id, rsp_data and rsp_all_ones stable; on rsp_ready = 1 go to IDLE; otherwise hold.
REQ-021 Latency: accept in cycle N; rsp_valid first high in cycle N+3.
REQ-022 Minimum issue interval is 4 cycles; the next grant occurs no earlier than the IDLE cycle after the rsp_ready handshake.
REQ-023 rr_ptr <= granted id + 1, modulo NREQ, on every grant; it is unchanged when there is no grant.
REQ-024 A requester that deasserts req_valid before being granted is not served; no request is queued internally.
REQ-025 rsp_data mirrors tgt at all times; it is also visible outside RESP but is qualified only by rsp_valid.
REQ-026 rst asserted in any state, including mid-command, aborts the command with no response.

Reset
REQ-027 On rst: state = IDLE, tgt = 4'h0, rr_ptr = 0, all_ones = 0.
REQ-028 On rst: rsp_valid = 0, rsp_id = 0, rsp_all_ones = 0, req_ready = 0.
REQ-029 The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-030 Package fill_pkg holds fill_struct_t (packed: logic [1:0] hi, logic [1:0] lo), the fill-code enum, the FSM state enum, and FILL_W = 4.
REQ-031 One sub-module, rr_pick: combinational round-robin one-hot picker (inputs req, ptr; outputs grant, id).

Verification
REQ-032 Reset, then req_valid=0001 with code 01: req_ready=0001 in the accept cycle; 3 cycles later rsp_valid=1, rsp_id=0, rsp_data=4'hF, rsp_all_ones=1.
REQ-033 All four requesters held valid continuously with rsp_ready=1: grants in order 0,1,2,3,0, spaced 4 cycles apart.
REQ-034 Sequence code 01, 11, 10: rsp_data = F, 0, 0; rsp_all_ones = 1, 0, 0.
REQ-035 rsp_ready=0 for 5 cycles in RESP: rsp_valid and all response fields stay stable, and req_ready stays 0.
REQ-036 rst asserted during CHECK: the next cycle is IDLE, rsp_valid=0, tgt=0, and no response is produced for the aborted command.
REQ-037 With rr_ptr=3, requesters 1 and 2 valid: the grant goes to 1 (wrap-around), and rr_ptr becomes 2.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types for the fill/check arbiter: target register layout, fill codes, FSM states.
package fill_pkg;
  localparam int FILL_W = 4;

  typedef struct packed {
    logic [1:0] hi;
    logic [1:0] lo;
  } fill_struct_t;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_ONE  = 2'b01,
    FILL_HOLD = 2'b10,
    FILL_INV  = 2'b11
  } fill_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_CHECK = 2'b10,
    ST_RESP  = 2'b11
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);
  logic w_found;
  int   w_idx;

  always_comb begin
    grant   = '0;
    id      = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        id           = IDW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/fill_check_arbiter.sv
// Round-robin arbiter applying one fill command at a time to a shared 4-bit target,
// then reporting the target and whether it is all ones.
module fill_check_arbiter
  import fill_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_fill,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output fill_struct_t        rsp_data,
  output logic                rsp_all_ones,
  input  logic                rsp_ready
);
  state_e       r_state, w_next;
  logic [IDW-1:0]  r_ptr, r_id, w_pick_id;
  logic [NREQ-1:0] w_pick;
  fill_code_e   r_code;
  fill_struct_t r_tgt;
  logic         r_all_ones;
  logic         w_grant;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_pick),
    .id    (w_pick_id)
  );

  // A grant shown while rst is high would never be accepted, so mask it.
  assign w_grant = (r_state == ST_IDLE) && (|req_valid) && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|req_valid) w_next = ST_APPLY;
      ST_APPLY: w_next = ST_CHECK;
      ST_CHECK: w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_grant ? w_pick : '0;
    rsp_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_code     <= FILL_ZERO;
      r_tgt      <= '0;
      r_all_ones <= 1'b0;
    end else begin
      if (w_grant) begin
        r_id   <= w_pick_id;
        r_code <= fill_code_e'(req_fill[2*int'(w_pick_id) +: 2]);
        r_ptr  <= (w_pick_id == IDW'(NREQ-1)) ? '0 : w_pick_id + IDW'(1);
      end
      if (r_state == ST_APPLY) begin
        case (r_code)
          FILL_ZERO: r_tgt <= '0;
          FILL_ONE:  r_tgt <= '1;
          FILL_HOLD: r_tgt <= r_tgt;
          FILL_INV:  r_tgt <= fill_struct_t'(~r_tgt);
          default:   r_tgt <= r_tgt;
        endcase
      end
      if (r_state == ST_CHECK) r_all_ones <= (r_tgt == '1);
    end
  end

  assign rsp_id       = r_id;
  assign rsp_data     = r_tgt;
  assign rsp_all_ones = r_all_ones;
endmodule

// File: tb/tb_fill_check_arbiter.sv
// Scoreboard bench for fill_check_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_fill_check_arbiter;
  import fill_pkg::*;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_fill;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  fill_struct_t      rsp_data;
  logic              rsp_all_ones;
  logic              rsp_ready;

  typedef struct {
    int         id;
    logic [3:0] data;
    logic       ao;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fill_check_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_fill     (req_fill),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_all_ones (rsp_all_ones),
    .rsp_ready    (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [3:0] data, input logic ao);
    exp_t e;
    e.id = id; e.data = data; e.ao = ao;
    exp_q.push_back(e);
  endtask

  // Caller sits just after a rising edge with the DUT in IDLE.
  task automatic issue(input logic [3:0] mask, input logic [7:0] fill, input int eid,
                       input logic [3:0] edata, input logic eao);
    req_valid = mask;
    req_fill  = fill;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(4'b0001 << eid));
    push(eid, edata, eao);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("lat1_valid", 32'(rsp_valid), 32'd0);
    chk("lat1_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("lat2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat3_valid", 32'(rsp_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual_id=%0d expected=none", rsp_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id",       32'(rsp_id),       32'(mon_e.id));
        chk("rsp_data",     32'(rsp_data),     32'(mon_e.data));
        chk("rsp_all_ones", 32'(rsp_all_ones), 32'(mon_e.ao));
      end
    end
  end

  initial begin
    int g, last;
    rst = 1'b1; req_valid = 4'hF; req_fill = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid),    32'd0);
    chk("rst_rsp_id",    32'(rsp_id),       32'd0);
    chk("rst_rsp_data",  32'(rsp_data),     32'd0);
    chk("rst_all_ones",  32'(rsp_all_ones), 32'd0);
    chk("rst_req_ready", 32'(req_ready),    32'd0);

    // Basic fill-ones from requester 0, first cycle after reset.
    tick(); rst = 1'b0;
    issue(4'b0001, 8'h01, 0, 4'hF, 1'b1);
    // Codes 01, 11, 10 from requesters 1, 2, 3 in turn.
    tick(); issue(4'b0010, 8'h04, 1, 4'hF, 1'b1);
    tick(); issue(4'b0100, 8'h30, 2, 4'h0, 1'b0);
    tick(); issue(4'b1000, 8'h80, 3, 4'h0, 1'b0);
    // ptr=0 -> grant 2 (fill 0), ptr=3; then 1 and 2 valid wraps to 1, ptr=2; then 2 wins.
    tick(); issue(4'b0100, 8'h00, 2, 4'h0, 1'b0);
    tick(); issue(4'b0110, 8'h34, 1, 4'hF, 1'b1);
    tick(); issue(4'b0110, 8'h34, 2, 4'h0, 1'b0);

    // All requesters held valid with invert codes: 0,1,2,3,0 every 4 cycles.
    tick(); rst = 1'b1;
    tick();
    tick(); rst = 1'b0; req_valid = 4'hF; req_fill = 8'hFF;
    g = 0; last = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (g % 4)));
        if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd4);
        push(g % 4, (g % 2 == 0) ? 4'hF : 4'h0, (g % 2 == 0));
        last = cyc;
        g++;
        if (g == 5) break;
      end
    end
    chk("rr_grant_count", 32'(g), 32'd5);
    tick(); req_valid = '0;
    repeat (4) @(negedge clk);

    // Consumer stall: response fields hold, no grants while requests wait.
    tick(); rsp_ready = 1'b0;
    issue(4'b0010, 8'h08, 1, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(); req_valid = 4'hF;
      @(negedge clk);
      chk("stall_valid",    32'(rsp_valid),    32'd1);
      chk("stall_id",       32'(rsp_id),       32'd1);
      chk("stall_data",     32'(rsp_data),     32'hF);
      chk("stall_all_ones", 32'(rsp_all_ones), 32'd1);
      chk("stall_ready",    32'(req_ready),    32'd0);
    end
    tick(); rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk);

    // Reset during CHECK aborts the command; then grant on the first free cycle.
    tick(); req_valid = 4'b0100; req_fill = 8'h10;
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'b0100);
    tick(); req_valid = '0;
    tick(); rst = 1'b1;
    tick(); req_valid = 4'hF;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid),    32'd0);
    chk("abort_tgt",       32'(rsp_data),     32'd0);
    chk("abort_all_ones",  32'(rsp_all_ones), 32'd0);
    chk("abort_req_ready", 32'(req_ready),    32'd0);
    tick(); rst = 1'b0;
    issue(4'b0001, 8'h01, 0, 4'hF, 1'b1);

    tick();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
